// File: rtl/shift_feeder_pkg.sv
// Shared types and helpers for the shift-register feeder: state encoding,
// direction codes and counter width sizing.
package shift_feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   // A one-state counter still needs a 1-bit register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_bit_cnt.sv
// Up-counter with synchronous clear (priority over increment) and a
// terminal-count flag raised while the count equals TERM.
module shift_bit_cnt #(
   parameter int CW   = 4,
   parameter int TERM = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CW'(TERM));

endmodule

// File: rtl/shift_feeder.sv
// Serialises handshaked parallel words onto d/en/dir for the downstream
// shift register, with an optional idle gap and a word_done pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for a word; in_ready follows alive
//   ST_SHIFT | presenting one bit per cycle, en=1
//   ST_GAP   | GAP idle cycles after a word, en=0, in_ready=0
module shift_feeder
   import shift_feeder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             d,
   output logic             en,
   output logic             dir,
   output logic             busy,
   output logic             word_done
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             alive_q;
   logic             bit_last;
   logic             gap_last;

   shift_bit_cnt #(
      .CW   (CNT_W),
      .TERM (WIDTH - 1)
   ) u_bit_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  ((state_q != ST_SHIFT) || bit_last),
      .inc_i  ((state_q == ST_SHIFT) && !bit_last),
      .tc_o   (bit_last)
   );

   if (GAP > 0) begin : g_gap
      shift_bit_cnt #(
         .CW   (cnt_width(GAP)),
         .TERM (GAP - 1)
      ) u_gap_cnt (
         .clk_i  (clk),
         .rst_ni (reset),
         .clr_i  (state_q != ST_GAP),
         .inc_i  (state_q == ST_GAP),
         .tc_o   (gap_last)
      );
   end else begin : g_no_gap
      assign gap_last = 1'b0;
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = alive_q;
            if (in_valid && alive_q) begin
               hold_d  = in_data;
               dir_d   = in_dir;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            hold_d = (dir_q == DIR_LSB_FIRST) ? (hold_q >> 1) : (hold_q << 1);
            if (bit_last) begin
               done_d = 1'b1;
               if (GAP > 0) begin
                  state_d = ST_GAP;
               end else begin
                  // Back-to-back: accept the next word on the last bit, no bubble.
                  in_ready = 1'b1;
                  if (in_valid) begin
                     hold_d = in_data;
                     dir_d  = in_dir;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         dir_q   <= DIR_MSB_FIRST;
         done_q  <= 1'b0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         alive_q <= 1'b1;
      end
   end

   assign en        = (state_q == ST_SHIFT);
   assign d         = en & ((dir_q == DIR_LSB_FIRST) ? hold_q[0] : hold_q[WIDTH-1]);
   assign dir       = dir_q;
   assign busy      = (state_q != ST_IDLE);
   assign word_done = done_q;

endmodule

// File: tb/tb_shift_feeder.sv
// Scoreboard bench for shift_feeder: two instances (GAP=0 and GAP=3) fed by
// independent producers, checked every cycle against a bit-stream model.
module tb_shift_feeder;

   localparam int W = 16;

   typedef struct {
      logic b;
      logic dr;
      logic last;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] in_data   [2];
   logic         in_dir    [2];
   logic         in_valid  [2];
   logic         in_ready  [2];
   logic         d         [2];
   logic         en        [2];
   logic         dir       [2];
   logic         busy      [2];
   logic         word_done [2];

   exp_t         exp_q  [2][$];
   logic [W-1:0] word_q [2][$];
   int           gap_left  [2];
   logic         done_next [2];
   logic         last_dir  [2];
   logic [W-1:0] sr        [2];
   logic         alive_m = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_feeder #(.WIDTH(W), .GAP(0)) u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data[0]),
      .in_dir    (in_dir[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .d         (d[0]),
      .en        (en[0]),
      .dir       (dir[0]),
      .busy      (busy[0]),
      .word_done (word_done[0])
   );

   shift_feeder #(.WIDTH(W), .GAP(3)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data[1]),
      .in_dir    (in_dir[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .d         (d[1]),
      .en        (en[1]),
      .dir       (dir[1]),
      .busy      (busy[1]),
      .word_done (word_done[1])
   );

   function automatic int gap_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, req, $time);
      end
   endtask

   // Once per cycle: compare outputs with the accepted-bit stream, then
   // record any acceptance happening at the coming edge.
   task automatic monitor(input int k);
      exp_t         e;
      logic [W-1:0] w;
      if (!reset) begin
         chk("rst_en", k, en[k], 0);
         chk("rst_busy", k, busy[k], 0);
         chk("rst_ready", k, in_ready[k], 0);
         chk("rst_done", k, word_done[k], 0);
         chk("rst_d", k, d[k], 0);
         chk("rst_dir", k, dir[k], 0);
         exp_q[k].delete();
         word_q[k].delete();
         gap_left[k]  = 0;
         done_next[k] = 1'b0;
         last_dir[k]  = 1'b0;
         return;
      end
      chk("word_done", k, word_done[k], done_next[k]);
      if (word_done[k]) begin
         if (word_q[k].size() == 0) chk("done_word_q", k, word_q[k].size(), 1);
         else chk("sr_word", k, sr[k], word_q[k].pop_front());
      end
      done_next[k] = 1'b0;
      if (exp_q[k].size() > 0) begin
         e = exp_q[k].pop_front();
         chk("en", k, en[k], 1);
         chk("d", k, d[k], e.b);
         chk("dir", k, dir[k], e.dr);
         chk("busy_shift", k, busy[k], 1);
         chk("ready_shift", k, in_ready[k], (gap_of(k) == 0) && e.last);
         sr[k] = dir[k] ? {d[k], sr[k][W-1:1]} : {sr[k][W-2:0], d[k]};
         last_dir[k] = e.dr;
         if (e.last) begin
            done_next[k] = 1'b1;
            gap_left[k]  = gap_of(k);
         end
      end else if (gap_left[k] > 0) begin
         chk("gap_en", k, en[k], 0);
         chk("gap_busy", k, busy[k], 1);
         chk("gap_ready", k, in_ready[k], 0);
         chk("gap_d", k, d[k], 0);
         chk("gap_dir", k, dir[k], last_dir[k]);
         gap_left[k]--;
      end else begin
         chk("idle_en", k, en[k], 0);
         chk("idle_busy", k, busy[k], 0);
         chk("idle_d", k, d[k], 0);
         chk("idle_ready", k, in_ready[k], alive_m);
         chk("idle_dir", k, dir[k], last_dir[k]);
      end
      if (in_valid[k] && in_ready[k]) begin
         w = in_data[k];
         word_q[k].push_back(w);
         for (int i = 0; i < W; i++) begin
            e.b    = in_dir[k] ? w[i] : w[W-1-i];
            e.dr   = in_dir[k];
            e.last = (i == W - 1);
            exp_q[k].push_back(e);
         end
      end
   endtask

   task automatic idle(input int k, input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_data[k] = W'($urandom);
         in_dir[k]  = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send(input int k, input logic [W-1:0] w, input logic dr);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      in_data[k]  = w;
      in_dir[k]   = dr;
      in_valid[k] = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready[k];
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("accept_timeout", k, n, 0);
      in_valid[k] = 1'b0;
      in_data[k]  = W'($urandom);
      in_dir[k]   = 1'($urandom_range(0, 1));
   endtask

   task automatic rand_traffic(input int k);
      repeat (20) begin
         send(k, W'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 5));
      end
      idle(k, 30);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         in_data[k]   = '0;
         in_dir[k]    = 1'b0;
         in_valid[k]  = 1'b0;
         gap_left[k]  = 0;
         done_next[k] = 1'b0;
         last_dir[k]  = 1'b0;
         sr[k]        = '0;
      end
      fork
         forever begin
            @(negedge clk);
            monitor(0);
            monitor(1);
         end
         forever begin
            @(posedge clk or negedge reset);
            alive_m = reset;
         end
      join_none

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(0, 3);

      for (int k = 0; k < 2; k++) begin
         send(k, 16'hA5C3, 1'b0);
         idle(k, 22);
         send(k, 16'hA5C3, 1'b1);
         idle(k, 22);
         send(k, 16'hFFFF, 1'b0);
         send(k, 16'h0000, 1'b0);
         idle(k, 40);
      end

      fork
         rand_traffic(0);
         rand_traffic(1);
      join

      send(0, 16'h1234, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      chk("pre_reset_en", 0, en[0], 1);
      reset = 1'b0;
      #1;
      chk("async_en", 0, en[0], 0);
      chk("async_busy", 0, busy[0], 0);
      chk("async_ready", 0, in_ready[0], 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      idle(0, 3);
      send(0, 16'h8001, 1'b0);
      idle(0, 25);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
